// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-sequencing unit: op encodings and
// the LFSR feedback used by the low-page program counter.
package pc_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_RETS = 3'd4;
  localparam logic [2:0] OP_LDPG = 3'd5;

  // Feedback bit shifted into the MSB of the low PC on each step.
  function automatic logic lfsr_fb(input logic b0, input logic b1);
    return ~(b0 ^ b1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address stack kept as a shift array with entry 0 as the top.
// A push onto a full stack either drops the oldest entry (OVF_DROP=1)
// or leaves the stack untouched (OVF_DROP=0); both report push_ovf.
module pc_return_stack #(
  parameter int W        = 10,
  parameter int DEPTH    = 4,
  parameter bit OVF_DROP = 1'b1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  tos,
  output logic [CW-1:0] count,
  output logic          push_ovf,
  output logic          pop_unf
);

  logic [W-1:0] entries [DEPTH];
  logic         full;
  logic         empty;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ovf = push && full;
  assign pop_unf  = pop && empty;
  assign tos      = empty ? '0 : entries[0];

  // Shift entries down on push and up on pop; occupancy tracks the depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      count <= '0;
    end else if (push) begin
      if (!full || OVF_DROP) begin
        for (int i = DEPTH - 1; i > 0; i--) entries[i] <= entries[i-1];
        entries[0] <= din;
      end
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
      entries[DEPTH-1] <= '0;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq_stack.sv
// Program-sequencing unit: LFSR low-page PC, page register, one-shot
// page prefix, return stack and sticky overflow/underflow flags.
// An accepted op always takes precedence over a concurrent step.
module pc_seq_stack
  import pc_seq_pkg::*;
#(
  parameter int               PL_W      = 6,
  parameter int               PU_W      = 4,
  parameter int               DEPTH     = 4,
  parameter logic [PU_W-1:0]  CALL_PAGE = {PU_W{1'b1}},
  parameter bit               OVF_DROP  = 1'b1,
  localparam int              PC_W      = PU_W + PL_W,
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             op_vld,
  input  logic [2:0]       op,
  input  logic [PL_W-1:0]  tgt,
  input  logic [PU_W-1:0]  pg,
  input  logic             flag_clr,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  tos,
  output logic [CW-1:0]    count,
  output logic             pend,
  output logic             skip,
  output logic             ovf,
  output logic             unf
);

  logic [PL_W-1:0] pl;
  logic [PU_W-1:0] pu;
  logic [PU_W-1:0] pend_pg;
  logic            is_jmp;
  logic            is_call;
  logic            is_ret;
  logic            is_rets;
  logic            is_ldpg;
  logic            push_ovf;
  logic            pop_unf;

  assign pc = {pu, pl};

  // Decode the accepted op; encodings 6-7 fall through as NOP.
  always_comb begin
    is_jmp  = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    is_rets = 1'b0;
    is_ldpg = 1'b0;
    if (op_vld) begin
      case (op)
        OP_JMP:  is_jmp  = 1'b1;
        OP_CALL: is_call = 1'b1;
        OP_RET:  is_ret  = 1'b1;
        OP_RETS: begin
          is_ret  = 1'b1;
          is_rets = 1'b1;
        end
        OP_LDPG: is_ldpg = 1'b1;
        default: ;
      endcase
    end
  end

  pc_return_stack #(
    .W        (PC_W),
    .DEPTH    (DEPTH),
    .OVF_DROP (OVF_DROP)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (is_call),
    .pop      (is_ret),
    .din      (pc),
    .tos      (tos),
    .count    (count),
    .push_ovf (push_ovf),
    .pop_unf  (pop_unf)
  );

  // PC, prefix, skip pulse and sticky flags; a new event beats flag_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      pl      <= '0;
      pu      <= '0;
      pend    <= 1'b0;
      pend_pg <= '0;
      skip    <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      skip <= 1'b0;
      ovf  <= push_ovf | (ovf & ~flag_clr);
      unf  <= pop_unf | (unf & ~flag_clr);
      if (op_vld) begin
        if (!is_ldpg) pend <= 1'b0;
        if (is_jmp) begin
          pl <= tgt;
          if (pend) pu <= pend_pg;
        end else if (is_call) begin
          pl <= tgt;
          pu <= pend ? pend_pg : CALL_PAGE;
        end else if (is_ret) begin
          if (count != '0) begin
            pu <= tos[PC_W-1:PL_W];
            pl <= tos[PL_W-1:0];
          end
          skip <= is_rets;
        end else if (is_ldpg && !pend) begin
          pend_pg <= pg;
          pend    <= 1'b1;
        end
      end else if (step) begin
        pl <= {lfsr_fb(pl[0], pl[1]), pl[PL_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_stack.sv
// Directed bench for pc_seq_stack. Two instances share stimulus: one
// drops the oldest entry on overflow, the other rejects the push.
module tb_pc_seq_stack;
  import pc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic       op_vld = 1'b0;
  logic [2:0] op = 3'd0;
  logic [5:0] tgt = 6'd0;
  logic [3:0] pg = 4'd0;
  logic       flag_clr = 1'b0;

  logic [9:0] pc, tos, pc0, tos0;
  logic [2:0] count, count0;
  logic       pend, skip, ovf, unf, pend0, skip0, ovf0, unf0;

  int tests_run = 0;
  int tests_failed = 0;

  pc_seq_stack #(.OVF_DROP(1'b1)) dut (
    .clk(clk), .rst(rst), .step(step), .op_vld(op_vld), .op(op), .tgt(tgt),
    .pg(pg), .flag_clr(flag_clr), .pc(pc), .tos(tos), .count(count),
    .pend(pend), .skip(skip), .ovf(ovf), .unf(unf)
  );

  pc_seq_stack #(.OVF_DROP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .step(step), .op_vld(op_vld), .op(op), .tgt(tgt),
    .pg(pg), .flag_clr(flag_clr), .pc(pc0), .tos(tos0), .count(count0),
    .pend(pend0), .skip(skip0), .ovf(ovf0), .unf(unf0)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then return #1 after the sampling edge.
  task automatic drive(input logic v, input logic [2:0] o, input logic [5:0] t,
                       input logic [3:0] p, input logic s, input logic fc,
                       input logic r);
    op_vld = v; op = o; tgt = t; pg = p; step = s; flag_clr = fc; rst = r;
    @(posedge clk);
    #1;
    op_vld = 1'b0; op = 3'd0; step = 1'b0; flag_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, OP_NOP, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({pc, tos, count, pend, skip, ovf, unf} !== {10'h0, 10'h0, 3'd0, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL reset: pc=%h tos=%h count=%0d pend=%b skip=%b ovf=%b unf=%b expected all zero",
               pc, tos, count, pend, skip, ovf, unf);
    end
  endtask

  task automatic test_lfsr();
    logic [5:0] exp_pl [6];
    exp_pl = '{6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110, 6'b011111};
    test_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, OP_NOP, 6'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (pc !== {4'd0, exp_pl[i]}) begin
        tests_failed++;
        $display("[TB] FAIL lfsr_step%0d: pc=%b expected %b", i, pc, {4'd0, exp_pl[i]});
      end
    end
  endtask

  task automatic test_prefix_jump();
    test_reset();
    drive(1'b1, OP_LDPG, 6'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (pend !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ldpg_pend: pend=%b expected 1", pend);
    end
    drive(1'b1, OP_LDPG, 6'd0, 4'd9, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_JMP, 6'h12, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({pc, pend} !== {10'h152, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL prefixed_jmp: pc=%h pend=%b expected pc=152 pend=0", pc, pend);
    end
    drive(1'b1, OP_JMP, 6'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (pc !== 10'h143) begin
      tests_failed++;
      $display("[TB] FAIL plain_jmp: pc=%h expected 143", pc);
    end
  endtask

  task automatic test_call_rets();
    test_reset();
    drive(1'b1, OP_LDPG, 6'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_JMP, 6'h10, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_CALL, 6'd7, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({pc, count, tos} !== {10'h3C7, 3'd1, 10'h090}) begin
      tests_failed++;
      $display("[TB] FAIL call: pc=%h count=%0d tos=%h expected pc=3c7 count=1 tos=090", pc, count, tos);
    end
    drive(1'b1, OP_RETS, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({pc, count, skip} !== {10'h090, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL rets: pc=%h count=%0d skip=%b expected pc=090 count=0 skip=1", pc, count, skip);
    end
    drive(1'b0, OP_NOP, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (skip !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL skip_width: skip=%b expected 0", skip);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_drop [4];
    logic [9:0] exp_rej [4];
    exp_drop = '{10'h3C5, 10'h3C4, 10'h3C3, 10'h3C2};
    exp_rej  = '{10'h3C4, 10'h3C3, 10'h3C2, 10'h001};
    test_reset();
    drive(1'b1, OP_JMP, 6'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, OP_CALL, 6'(i + 2), 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({count, ovf, tos, count0, ovf0, tos0} !== {3'd4, 1'b1, 10'h3C5, 3'd4, 1'b1, 10'h3C4}) begin
      tests_failed++;
      $display("[TB] FAIL overflow: drop count=%0d ovf=%b tos=%h reject count=%0d ovf=%b tos=%h expected 4/1/3c5 and 4/1/3c4",
               count, ovf, tos, count0, ovf0, tos0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_RET, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ({pc, pc0} !== {exp_drop[i], exp_rej[i]}) begin
        tests_failed++;
        $display("[TB] FAIL ovf_ret%0d: drop pc=%h reject pc=%h expected %h and %h",
                 i, pc, pc0, exp_drop[i], exp_rej[i]);
      end
    end
    tests_run++;
    if ({count, count0, tos} !== {3'd0, 3'd0, 10'h000}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_drain: count=%0d count0=%0d tos=%h expected 0 0 000", count, count0, tos);
    end
  endtask

  task automatic test_underflow();
    test_reset();
    drive(1'b1, OP_JMP, 6'h21, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_RET, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({pc, count, unf} !== {10'h021, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL underflow: pc=%h count=%0d unf=%b expected 021 0 1", pc, count, unf);
    end
    drive(1'b0, OP_NOP, 6'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (unf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flag_clr: unf=%b expected 0", unf);
    end
    drive(1'b1, OP_RETS, 6'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({pc, unf, skip} !== {10'h021, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL clr_vs_event: pc=%h unf=%b skip=%b expected 021 1 1", pc, unf, skip);
    end
  endtask

  task automatic test_priority_reset();
    test_reset();
    drive(1'b1, OP_LDPG, 6'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_JMP, 6'd9, 4'd0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if ({pc, pend} !== {10'h0C9, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL step_vs_op: pc=%h pend=%b expected 0c9 0", pc, pend);
    end
    drive(1'b1, OP_CALL, 6'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_RET, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({pc, count} !== {10'h0C9, 3'd0}) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: pc=%h count=%0d expected 0c9 0", pc, count);
    end
    drive(1'b1, OP_RET, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_CALL, 6'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_LDPG, 6'd0, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_CALL, 6'd6, 4'd0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({pc, tos, count, pend, skip, ovf, unf} !== {10'h0, 10'h0, 3'd0, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL reset_during_call: pc=%h tos=%h count=%0d pend=%b skip=%b ovf=%b unf=%b expected all zero",
               pc, tos, count, pend, skip, ovf, unf);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_prefix_jump();
    test_call_rets();
    test_overflow();
    test_underflow();
    test_priority_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
